// File: rtl/sequential_divider.sv
// Iterative restoring divider: resolves one quotient bit per clock behind a start/busy/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands with a quotient that truncates toward zero.
module sequential_divider #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  divByZero
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;

    logic [DATA_WIDTH-1:0] part_rem, dvd_shift, dsr;
    logic [CNT_W-1:0]      count;
    logic                  accept, div_zero, last_iter;
    logic [DATA_WIDTH:0]   rem_shift, trial;
    logic [DATA_WIDTH-1:0] rem_next, quot_next, quot_res, rem_res;
    logic [DATA_WIDTH-1:0] dvd_mag, dsr_mag, zero_quot;

`ifdef DIVIDER_SIGNED_EN
    logic quot_neg, rem_neg;

    function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] x);
        return ~x + DATA_WIDTH'(1);
    endfunction

    // The most-negative value maps onto 2^(DATA_WIDTH-1), which still fits unsigned.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? negate(x) : x;
    endfunction
`endif

    always_comb begin
        accept    = start && (state != CALC);
        div_zero  = (divisor == '0);
        last_iter = (count == CNT_W'(1));
        // The extra top bit keeps the carry of the shifted partial remainder.
        rem_shift = {part_rem, dvd_shift[DATA_WIDTH-1]};
        trial     = rem_shift - {1'b0, dsr};
        rem_next  = trial[DATA_WIDTH] ? rem_shift[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
        quot_next = {dvd_shift[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
`ifdef DIVIDER_SIGNED_EN
        dvd_mag   = magnitude(dividend);
        dsr_mag   = magnitude(divisor);
        zero_quot = dividend[DATA_WIDTH-1] ? DATA_WIDTH'(1) : '1;
        quot_res  = quot_neg ? negate(quot_next) : quot_next;
        rem_res   = rem_neg ? negate(rem_next) : rem_next;
`else
        dvd_mag   = dividend;
        dsr_mag   = divisor;
        zero_quot = '1;
        quot_res  = quot_next;
        rem_res   = rem_next;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = div_zero ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = div_zero ? DONE : CALC;
                else       state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Results load only on the edge entering DONE, so they hold everywhere else.
    always_ff @(posedge clock) begin
        if (reset) begin
            part_rem  <= '0;
            dvd_shift <= '0;
            dsr       <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            divByZero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            quot_neg  <= 1'b0;
            rem_neg   <= 1'b0;
`endif
        end else if (accept) begin
            part_rem  <= '0;
            dvd_shift <= dvd_mag;
            dsr       <= dsr_mag;
            count     <= CNT_W'(DATA_WIDTH);
`ifdef DIVIDER_SIGNED_EN
            quot_neg  <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
            rem_neg   <= dividend[DATA_WIDTH-1];
`endif
            if (div_zero) begin
                quotient  <= zero_quot;
                remainder <= dividend;
                divByZero <= 1'b1;
            end
        end else if (state == CALC) begin
            part_rem  <= rem_next;
            dvd_shift <= quot_next;
            count     <= count - CNT_W'(1);
            if (last_iter) begin
                quotient  <= quot_res;
                remainder <= rem_res;
                divByZero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: expected results queued at start, compared at done.
module tb_sequential_divider;
    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset, start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, divByZero;
    logic [W-1:0] quotient, remainder;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } res_t;

    res_t sb[$];
    int   tests = 0;
    int   fails = 0;

    sequential_divider #(.DATA_WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .divByZero(divByZero)
    );

    always #5 clock = ~clock;

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t m;
`ifdef DIVIDER_SIGNED_EN
        logic signed [W-1:0] sa, sd;
        sa = a;
        sd = b;
        m.dbz = 1'b0;
        if (b == '0) begin
            m.q   = (sa < 0) ? W'(1) : '1;
            m.r   = a;
            m.dbz = 1'b1;
        end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            m.q = a;
            m.r = '0;
        end else begin
            m.q = sa / sd;
            m.r = sa % sd;
        end
`else
        m.dbz = 1'b0;
        if (b == '0) begin
            m.q   = '1;
            m.r   = a;
            m.dbz = 1'b1;
        end else begin
            m.q = a / b;
            m.r = a % b;
        end
`endif
        return m;
    endfunction

    // Drives one start pulse and queues the expected result; returns in cycle 1 after acceptance.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 64) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        res_t got;
        reset = 1'b1; start = 1'b1; dividend = 16'd10; divisor = 16'd2;
        repeat (3) @(negedge clock);
        tests++;
        if ({busy, done, divByZero, quotient, remainder} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%h r=%h want all zero",
                     busy, done, divByZero, quotient, remainder);
        end
        reset = 1'b0; start = 1'b0;
        @(negedge clock);
        got = {quotient, remainder, divByZero};
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || got !== '0) begin
            fails++;
            $display("FAIL reset_release: got busy=%b done=%b q=%h r=%h want idle zeros",
                     busy, done, quotient, remainder);
        end
    endtask

    task automatic test_basic();
        int   lat, nbusy;
        res_t exp, got;
        start_op(16'd100, 16'd7);
        lat = 1; nbusy = 0;
        while (done !== 1'b1 && lat < 64) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clock);
            lat++;
        end
        tests++;
        if (nbusy !== 16) begin
            fails++; $display("FAIL basic_busy_cycles: got %0d want 16", nbusy);
        end
        tests++;
        if (lat !== 17) begin
            fails++; $display("FAIL basic_latency: got %0d want 17", lat);
        end
        exp = sb.pop_front();
        got = {quotient, remainder, divByZero};
        tests++;
        if (got !== exp || quotient !== 16'd14 || remainder !== 16'd2) begin
            fails++;
            $display("FAIL basic_result: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                     got.q, got.r, got.dbz, exp.q, exp.r, exp.dbz);
        end
        @(negedge clock);
        tests++;
        if (done !== 1'b0 || quotient !== exp.q) begin
            fails++; $display("FAIL basic_hold: got done=%b q=%h want done=0 q=%h", done, quotient, exp.q);
        end
    endtask

    task automatic test_edges();
        logic [W-1:0] ea[4] = '{16'hFFFF, 16'd3, 16'd0, 16'h8000};
        logic [W-1:0] eb[4] = '{16'd1, 16'd10, 16'd5, 16'h8000};
        int   lat;
        res_t exp, got;
        for (int i = 0; i < 4; i++) begin
            start_op(ea[i], eb[i]);
            wait_done(lat);
            tests++;
            if (lat !== 17) begin
                fails++; $display("FAIL edge%0d_latency: got %0d want 17", i, lat);
            end
            exp = sb.pop_front();
            got = {quotient, remainder, divByZero};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL edge%0d_result: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                         i, got.q, got.r, got.dbz, exp.q, exp.r, exp.dbz);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int   lat;
        res_t exp, got;
        start_op(16'd5, 16'd0);
        wait_done(lat);
        tests++;
        if (lat !== 1) begin
            fails++; $display("FAIL dbz_latency: got %0d want 1", lat);
        end
        exp = sb.pop_front();
        got = {quotient, remainder, divByZero};
        tests++;
        if (got !== exp || got.dbz !== 1'b1) begin
            fails++;
            $display("FAIL dbz_result: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                     got.q, got.r, got.dbz, exp.q, exp.r, exp.dbz);
        end
        start_op(16'd9, 16'd3);
        tests++;
        if (divByZero !== 1'b1) begin
            fails++; $display("FAIL dbz_held_while_busy: got %b want 1", divByZero);
        end
        wait_done(lat);
        exp = sb.pop_front();
        got = {quotient, remainder, divByZero};
        tests++;
        if (got !== exp || got.dbz !== 1'b0) begin
            fails++;
            $display("FAIL dbz_clear: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                     got.q, got.r, got.dbz, exp.q, exp.r, exp.dbz);
        end
    endtask

    task automatic test_handshake();
        int   lat;
        res_t exp, got;
        start_op(16'd100, 16'd7);
        repeat (3) @(negedge clock);
        start = 1'b1; dividend = 16'd50; divisor = 16'd3;
        @(negedge clock);
        start = 1'b0; dividend = 16'd1; divisor = 16'd1;
        wait_done(lat);
        tests++;
        if (lat !== 13) begin
            fails++; $display("FAIL ignore_start_latency: got %0d want 13", lat);
        end
        exp = sb.pop_front();
        got = {quotient, remainder, divByZero};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL ignore_start_result: got q=%h r=%h want q=%h r=%h", got.q, got.r, exp.q, exp.r);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        res_t exp, got;
        start_op(16'd1000, 16'd33);
        wait_done(lat);
        exp = sb.pop_front();
        got = {quotient, remainder, divByZero};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL b2b_first: got q=%h r=%h want q=%h r=%h", got.q, got.r, exp.q, exp.r);
        end
        start = 1'b1; dividend = 16'd500; divisor = 16'd9;
        sb.push_back(model(16'd500, 16'd9));
        @(negedge clock);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL b2b_accept: got busy=%b want 1", busy);
        end
        wait_done(lat);
        tests++;
        if (lat !== 17) begin
            fails++; $display("FAIL b2b_latency: got %0d want 17", lat);
        end
        exp = sb.pop_front();
        got = {quotient, remainder, divByZero};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL b2b_second: got q=%h r=%h want q=%h r=%h", got.q, got.r, exp.q, exp.r);
        end
    endtask

    task automatic test_reset_mid_op();
        int ndone;
        @(negedge clock);
        start = 1'b1; dividend = 16'd40000; divisor = 16'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if ({busy, done, quotient, remainder, divByZero} !== '0) begin
            fails++;
            $display("FAIL midop_reset: got busy=%b done=%b q=%h r=%h dbz=%b want all zero",
                     busy, done, quotient, remainder, divByZero);
        end
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (done === 1'b1) ndone++;
        end
        tests++;
        if (ndone !== 0) begin
            fails++; $display("FAIL midop_no_done: got %0d done strobes want 0", ndone);
        end
    endtask

    task automatic test_random();
        int           lat;
        logic [W-1:0] a, b;
        res_t         exp, got;
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom);
            b = (i % 3 == 0) ? W'($urandom_range(1, 15)) : W'($urandom);
            if (b == '0) b = W'(1);
            start_op(a, b);
            wait_done(lat);
            exp = sb.pop_front();
            got = {quotient, remainder, divByZero};
            tests++;
            if (got !== exp || lat !== 17) begin
                fails++;
                $display("FAIL random%0d %h/%h: got q=%h r=%h lat=%0d want q=%h r=%h lat=17",
                         i, a, b, got.q, got.r, lat, exp.q, exp.r);
            end
        end
    endtask

`ifdef DIVIDER_SIGNED_EN
    task automatic test_signed();
        logic [W-1:0] sa[4] = '{16'hFFF9, 16'd7, 16'h8000, 16'hFFFB};
        logic [W-1:0] sd[4] = '{16'd2, 16'hFFFE, 16'hFFFF, 16'd0};
        logic [W-1:0] wq[4] = '{16'hFFFD, 16'hFFFD, 16'h8000, 16'h0001};
        logic [W-1:0] wr[4] = '{16'hFFFF, 16'h0001, 16'h0000, 16'hFFFB};
        int   lat;
        res_t exp, got;
        for (int i = 0; i < 4; i++) begin
            start_op(sa[i], sd[i]);
            wait_done(lat);
            exp = sb.pop_front();
            got = {quotient, remainder, divByZero};
            tests++;
            if (got !== exp || got.q !== wq[i] || got.r !== wr[i]) begin
                fails++;
                $display("FAIL signed%0d: got q=%h r=%h want q=%h r=%h", i, got.q, got.r, wq[i], wr[i]);
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        test_reset();
        test_basic();
        test_edges();
        test_div_by_zero();
        test_handshake();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
`ifdef DIVIDER_SIGNED_EN
        test_signed();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
